// File: rtl/prod_accum.sv
// Run-length product accumulator: one product per cycle, result valid the cycle after the last accept.
// Result is held in DONE until out_ready; define ACCUM_SAT_EN to clamp on overflow instead of wrapping.
module prod_accum #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [CNT_WIDTH-1:0]    num_samples,
    input  logic [SHIFT_WIDTH-1:0]  shift,
    input  logic [2*DATA_WIDTH-1:0] p_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_WIDTH-1:0]    acc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sat_flag
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   count_inc;
    logic [ACC_WIDTH-1:0]   sum_w;
    logic                   accept;

    logic signed [2*DATA_WIDTH-1:0] p_s;
    logic signed [ACC_WIDTH-1:0]    p_ext;
    logic signed [ACC_WIDTH-1:0]    p_sh;

    assign p_s   = p_in;
    assign p_ext = ACC_WIDTH'(p_s);
    // Shifts past the product width naturally collapse to 0 or -1 via sign fill.
    assign p_sh  = p_ext >>> shift;

`ifdef ACCUM_SAT_EN
    logic                 sat_q, sat_d;
    logic                 ovf_w;
    logic [ACC_WIDTH:0]   wide_w;

    assign wide_w = {acc_q[ACC_WIDTH-1], acc_q} + {p_sh[ACC_WIDTH-1], p_sh};
    assign ovf_w  = wide_w[ACC_WIDTH] ^ wide_w[ACC_WIDTH-1];

    always_comb begin
        sum_w = wide_w[ACC_WIDTH-1:0];
        if (ovf_w) begin
            sum_w = wide_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign sat_flag = sat_q;
`else
    assign sum_w    = acc_q + p_sh;
    assign sat_flag = 1'b0;
`endif

    assign in_ready  = (state_q == ACCUM) & ~clear;
    assign accept    = in_valid & in_ready;
    assign count_inc = count_q + CNT_WIDTH'(1);
    assign acc_out   = acc_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) | (state_q == DONE);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        num_d   = num_q;
`ifdef ACCUM_SAT_EN
        sat_d   = sat_q;
`endif
        if (clear) begin
            acc_d   = '0;
            count_d = '0;
            num_d   = num_samples;
`ifdef ACCUM_SAT_EN
            sat_d   = 1'b0;
`endif
            state_d = (num_samples == '0) ? DONE : ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d   = sum_w;
                        count_d = count_inc;
`ifdef ACCUM_SAT_EN
                        sat_d   = sat_q | ovf_w;
`endif
                        if (count_inc == num_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            num_q   <= '0;
`ifdef ACCUM_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            num_q   <= num_d;
`ifdef ACCUM_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: stimulus queues expected results, a monitor checks every valid output.
module tb_prod_accum;

    localparam int DW = 16;
    localparam int AW = 33;
    localparam int SW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [CW-1:0] num_samples;
    logic [SW-1:0] shift;
    logic [2*DW-1:0] p_in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] acc_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          sat_flag;

    int total = 0;
    int bad   = 0;
    logic [AW:0] exp_q[$];

`ifdef ACCUM_SAT_EN
    localparam longint OVF_ACC = 64'sd4294967295;
    localparam logic   OVF_SAT = 1'b1;
`else
    localparam longint OVF_ACC = -64'sd4294967296;
    localparam logic   OVF_SAT = 1'b0;
`endif

    prod_accum #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .SHIFT_WIDTH(SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .num_samples(num_samples),
        .shift      (shift),
        .p_in       (p_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] a(input longint v);
        return AW'(v);
    endfunction

    task automatic push(input longint acc, input logic sat);
        exp_q.push_back({sat, a(acc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        num_samples = CW'(n);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input int sh);
        p_in     = p;
        shift    = SW'(sh);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got acc 0x%0h with no expected entry", acc_out);
            end else begin
                check("result_acc", 64'(acc_out), 64'(exp_q[0][AW-1:0]));
                check("result_sat", 64'(sat_flag), 64'(exp_q[0][AW]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        num_samples = '0; shift = '0; p_in = '0;
        #2;
        check("rst_acc", 64'(acc_out), 64'd0);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_iready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Basic run
        push(80, 1'b0);
        start(4);
        check("accum_busy", 64'(busy), 64'd1);
        send(100, 0); send(-30, 0); send(7, 0);
        check("not_done_early", 64'(out_valid), 64'd0);
        send(3, 0);
        check("ovalid_after_last", 64'(out_valid), 64'd1);
        step();
        check("idle_ovalid", 64'(out_valid), 64'd0);
        check("idle_hold_acc", 64'(acc_out), 64'(a(80)));
        check("idle_iready", 64'(in_ready), 64'd0);
        send(999, 0);
        check("idle_ignores_input", 64'(acc_out), 64'(a(80)));

        // Arithmetic shift
        push(-2, 1'b0);
        start(1); send(-5, 2); step();
        push(-1, 1'b0);
        start(1); send(-5, 40); step();

        // Overflow
        push(OVF_ACC, OVF_SAT);
        start(4);
        for (int i = 0; i < 4; i++) send(32'h4000_0000, 0);
        step();
        check("sat_sticky_idle", 64'(sat_flag), 64'(OVF_SAT));

        // Clear mid-run with a simultaneous sample
        start(3); send(50, 0); send(60, 0);
        check("partial_acc", 64'(acc_out), 64'(a(110)));
        p_in = 32'd1000; in_valid = 1'b1; num_samples = 8'd2; clear = 1'b1;
        #1;
        check("clear_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_zero_acc", 64'(acc_out), 64'd0);
        check("clear_zero_sat", 64'(sat_flag), 64'd0);
        push(11, 1'b0);
        send(5, 0); send(6, 0); step();

        // Backpressure in DONE
        out_ready = 1'b0;
        push(30, 1'b0);
        start(2); send(10, 0); send(20, 0);
        repeat (3) step();
        check("bp_ovalid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_release_ovalid", 64'(out_valid), 64'd0);
        check("bp_release_busy", 64'(busy), 64'd0);

        // Zero-length run
        push(0, 1'b0);
        start(0);
        check("zero_len_done", 64'(out_valid), 64'd1);
        step();

        // Reset mid-run
        start(4); send(100, 0); send(-30, 0);
        check("pre_rst_acc", 64'(acc_out), 64'(a(70)));
        rst = 1'b1;
        #1;
        check("midrst_acc", 64'(acc_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_iready", 64'(in_ready), 64'd0);
        check("midrst_ovalid", 64'(out_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
        push(-5, 1'b0);
        start(1); send(-5, 0); step();

        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
